avalon_pio_ext: RTL and testbench

- Parametrised Avalon-MM slave PIO block. It is the next generation of the team's single-register output port.
- Adds the following to the output register:
  - configurable width and reset value;
  - atomic bit set/clear and output readback;
  - synchronised input port with edge capture;
  - maskable interrupt.
- Sits on the system interconnect, driving LEDs/control lines and sampling switches/status lines from the processor.

---
 rtl/avalon_pio_ext.sv | 145 ++++++++++++++
 tb/tb_avalon_pio_ext.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_ext.sv
// Avalon-MM PIO slave: output register with set/clear, synchronised
// input port with edge capture, and a maskable interrupt.
module avalon_pio_ext #(
    parameter int unsigned               DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]     RESET_VALUE = '0,
    parameter int unsigned               SYNC_STAGES = 2,
    parameter int unsigned               EDGE_TYPE   = 0,
    parameter int unsigned               IRQ_TYPE    = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_MASK = 3'd1;
    localparam logic [2:0] ADDR_EDGE = 3'd2;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;
    localparam logic [2:0] ADDR_OUT  = 3'd6;

    typedef logic [DATA_WIDTH-1:0] word_t;

    logic  wr_en;
    logic  we_data;
    logic  we_mask;
    logic  we_edge;
    logic  we_set;
    logic  we_clr;
    word_t wdata;
    logic  unused_wdata;

    word_t data_out;
    word_t data_next;
    word_t irq_mask;
    word_t edge_cap;
    word_t cap_next;
    word_t w1c;

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
    word_t sin;
    word_t prev;
    word_t rise;
    word_t fall;
    word_t det;
    word_t irq_src;
    word_t rd_word;

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[DATA_WIDTH-1:0];
    assign unused_wdata = ^writedata;

    assign we_data = wr_en && (address == ADDR_DATA);
    assign we_mask = wr_en && (address == ADDR_MASK);
    assign we_edge = wr_en && (address == ADDR_EDGE);
    assign we_set  = wr_en && (address == ADDR_SET);
    assign we_clr  = wr_en && (address == ADDR_CLR);

    always_comb begin
        data_next = data_out;
        unique case (1'b1)
            we_data: data_next = wdata;
            we_set:  data_next = data_out | wdata;
            we_clr:  data_next = data_out & ~wdata;
            default: data_next = data_out;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
        end else begin
            data_out <= data_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (we_mask) begin
            irq_mask <= wdata;
        end
    end

    // Input synchroniser; prev trails the last stage for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev   <= sin;
        end
    end

    assign sin  = sync_q[SYNC_STAGES-1];
    assign rise = sin & ~prev;
    assign fall = ~sin & prev;

    always_comb begin
        det = rise | fall;
        case (EDGE_TYPE)
            0:       det = rise;
            1:       det = fall;
            default: det = rise | fall;
        endcase
    end

    // A fresh edge overrides a simultaneous write-1-to-clear
    assign w1c      = we_edge ? wdata : '0;
    assign cap_next = (edge_cap & ~w1c) | det;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= cap_next;
        end
    end

    assign irq_src  = (IRQ_TYPE == 0) ? sin : edge_cap;
    assign irq      = |(irq_src & irq_mask);
    assign out_port = data_out;

    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA: rd_word = sin;
            ADDR_MASK: rd_word = irq_mask;
            ADDR_EDGE: rd_word = edge_cap;
            ADDR_OUT:  rd_word = data_out;
            default:   rd_word = '0;
        endcase
    end

    assign readdata = 32'(rd_word);

endmodule

// File: tb/tb_avalon_pio_ext.sv
// Bench for avalon_pio_ext: three configurations on one shared bus,
// compared every cycle against a delay-line register model.
module tb_avalon_pio_ext;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b1;
    logic [2:0]  address    = 3'd6;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = '0;
    logic [31:0] in_bus     = '0;

    logic [31:0] rd0, rd1, rd2;
    logic [7:0]  op0, op1;
    logic [31:0] op2;
    logic        irq0, irq1, irq2;

    logic [31:0] act_rd [3];
    logic [31:0] act_op [3];
    logic        act_irq [3];

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;

    always #5 clk = ~clk;

    avalon_pio_ext #(
        .DATA_WIDTH(8), .RESET_VALUE(8'hA5), .SYNC_STAGES(2),
        .EDGE_TYPE(0), .IRQ_TYPE(1)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd0),
        .in_port(in_bus[7:0]), .out_port(op0), .irq(irq0)
    );

    avalon_pio_ext #(
        .DATA_WIDTH(8), .RESET_VALUE(8'h3C), .SYNC_STAGES(2),
        .EDGE_TYPE(2), .IRQ_TYPE(0)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd1),
        .in_port(in_bus[7:0]), .out_port(op1), .irq(irq1)
    );

    avalon_pio_ext #(
        .DATA_WIDTH(32), .RESET_VALUE(32'h8000_0001), .SYNC_STAGES(3),
        .EDGE_TYPE(1), .IRQ_TYPE(1)
    ) u2 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd2),
        .in_port(in_bus), .out_port(op2), .irq(irq2)
    );

    assign act_rd[0]  = rd0;
    assign act_rd[1]  = rd1;
    assign act_rd[2]  = rd2;
    assign act_op[0]  = {24'h0, op0};
    assign act_op[1]  = {24'h0, op1};
    assign act_op[2]  = op2;
    assign act_irq[0] = irq0;
    assign act_irq[1] = irq1;
    assign act_irq[2] = irq2;

    // Per-instance configuration
    function automatic int p_dw(int i);
        return (i == 2) ? 32 : 8;
    endfunction
    function automatic int p_ss(int i);
        return (i == 2) ? 3 : 2;
    endfunction
    function automatic int p_et(int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
    endfunction
    function automatic int p_it(int i);
        return (i == 1) ? 0 : 1;
    endfunction
    function automatic logic [31:0] p_rv(int i);
        return (i == 0) ? 32'hA5 : ((i == 1) ? 32'h3C : 32'h8000_0001);
    endfunction
    function automatic logic [31:0] wm(int i);
        return (p_dw(i) == 32) ? 32'hFFFF_FFFF : ((32'h1 << p_dw(i)) - 32'h1);
    endfunction

    // Model state: m_hist[i][k] = in_port sampled k+1 edges ago
    logic [31:0] m_dout [3];
    logic [31:0] m_mask [3];
    logic [31:0] m_cap  [3];
    logic [31:0] m_hist [3][4];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_dout[i] = p_rv(i);
            m_mask[i] = '0;
            m_cap[i]  = '0;
            for (int k = 0; k < 4; k++) m_hist[i][k] = '0;
        end
    endtask

    task automatic model_step();
        logic        wr;
        logic [31:0] wd, sn, pv, det, clr;
        wr = chipselect && !write_n;
        for (int i = 0; i < 3; i++) begin
            wd  = writedata & wm(i);
            sn  = m_hist[i][p_ss(i)-1];
            pv  = m_hist[i][p_ss(i)];
            case (p_et(i))
                0:       det = sn & ~pv;
                1:       det = ~sn & pv;
                default: det = sn ^ pv;
            endcase
            clr = (wr && address == 3'd2) ? wd : 32'h0;
            m_cap[i] = (m_cap[i] & ~clr) | det;
            if (wr) begin
                case (address)
                    3'd0: m_dout[i] = wd;
                    3'd1: m_mask[i] = wd;
                    3'd4: m_dout[i] = m_dout[i] | wd;
                    3'd5: m_dout[i] = m_dout[i] & ~wd;
                    default: ;
                endcase
            end
            for (int k = 3; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = in_bus & wm(i);
        end
    endtask

    function automatic logic [31:0] exp_rd(int i, logic [2:0] a);
        case (a)
            3'd0:    return m_hist[i][p_ss(i)-1];
            3'd1:    return m_mask[i];
            3'd2:    return m_cap[i];
            3'd6:    return m_dout[i];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic exp_irq(int i);
        logic [31:0] src;
        src = (p_it(i) == 0) ? m_hist[i][p_ss(i)-1] : m_cap[i];
        return |(src & m_mask[i]);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (reset_n) model_step();
    end

    initial forever begin
        @(negedge reset_n);
        model_reset();
    end

    initial forever begin
        @(negedge clk);
        if (!done) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d out_port", i), act_op[i], m_dout[i]);
                chk($sformatf("u%0d irq", i), 32'(act_irq[i]), 32'(exp_irq(i)));
                chk($sformatf("u%0d readdata a%0d", i, address),
                    act_rd[i], exp_rd(i, address));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(logic [2:0] a, logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(logic [2:0] a);
        address = a;
        #1;
    endtask

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("rst out u0", act_op[0], 32'hA5);
        chk("rst rd6 u0", act_rd[0], 32'h0000_00A5);
        chk("rst irq u0", 32'(act_irq[0]), 32'h0);
        chk("rst out u2", act_op[2], 32'h8000_0001);
        @(posedge clk);
        #1 reset_n = 1'b1;

        bus_write(3'd0, 32'h0F);
        chk("wr data", act_op[0], 32'h0F);
        bus_write(3'd4, 32'hF0);
        chk("wr set", act_op[0], 32'hFF);
        bus_write(3'd5, 32'h3C);
        chk("wr clr", act_op[0], 32'hC3);
        chipselect = 1'b0;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'h0;
        idle(1);
        write_n = 1'b1;
        chk("cs0 write", act_op[0], 32'hC3);
        rd(3'd6);
        chk("rd6 u0", act_rd[0], 32'hC3);

        bus_write(3'd1, 32'h01);
        in_bus = 32'h1;
        idle(2);
        rd(3'd2);
        chk("cap n+1", act_rd[0], 32'h0);
        idle(1);
        chk("cap n+2", act_rd[0], 32'h1);
        chk("irq edge", 32'(act_irq[0]), 32'h1);
        bus_write(3'd2, 32'h01);
        chk("w1c cap", act_rd[0], 32'h0);
        chk("w1c irq", 32'(act_irq[0]), 32'h0);
        in_bus = 32'h0;
        idle(4);
        chk("fall ignored", act_rd[0], 32'h0);

        in_bus = 32'h8;
        idle(2);
        bus_write(3'd2, 32'h08);
        chk("set wins", act_rd[0], 32'h08);
        bus_write(3'd2, 32'h08);
        chk("w1c after", act_rd[0], 32'h0);

        bus_write(3'd1, 32'h0);
        in_bus = 32'h80;
        idle(3);
        chk("lvl masked", 32'(act_irq[1]), 32'h0);
        bus_write(3'd1, 32'h80);
        chk("lvl irq", 32'(act_irq[1]), 32'h1);
        in_bus = 32'h0;
        idle(1);
        chk("lvl hold", 32'(act_irq[1]), 32'h1);
        idle(1);
        chk("lvl drop", 32'(act_irq[1]), 32'h0);

        idle(3);
        bus_write(3'd2, 32'hFFFF_FFFF);
        chk("cap clr u1", act_rd[1], 32'h0);
        in_bus = 32'h2;
        idle(3);
        chk("any rise", act_rd[1], 32'h2);
        idle(1);
        in_bus = 32'h0;
        idle(4);
        chk("any fall", act_rd[1], 32'h2);

        #1 reset_n = 1'b0;
        #1;
        chk("rst cap u1", act_rd[1], 32'h0);
        chk("rst irq u0", 32'(act_irq[0]), 32'h0);
        chk("rst irq u1", 32'(act_irq[1]), 32'h0);
        chk("rst irq u2", 32'(act_irq[2]), 32'h0);
        chk("rst out u0b", act_op[0], 32'hA5);
        @(posedge clk);
        #1 reset_n = 1'b1;

        repeat (3000) begin
            @(posedge clk);
            #1;
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 2) != 0);
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0)
                in_bus = in_bus ^ (32'h1 << $urandom_range(0, 31));
            if ($urandom_range(0, 63) == 0)
                in_bus = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                #2 reset_n = 1'b0;
                @(posedge clk);
                #1 reset_n = 1'b1;
            end
        end

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
